mem_dbus_ctrl: RTL and testbench

MEM-stage data-bus access controller, directly downstream of the EXE stage.
- Consumes the EXE/MEM-registered address (ALU result), store data, byte write-enables, load type and final exception flag.
- Issues one request/response transaction on the SRAM-like data bus and stalls the pipeline until it completes.
- Returns sign/zero-extended, byte-aligned load data to the MEM/WB path.

---
 rtl/mem_dbus_ctrl_pkg.sv | 35 +++
 rtl/mem_dbus_ctrl_load_align.sv | 31 +++
 rtl/mem_dbus_ctrl.sv | 171 +++++++++++++++++
 tb/tb_mem_dbus_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_dbus_ctrl_pkg.sv
// Shared CPU definitions: data-bus FSM states, load-size codes and store lane helpers.
package mem_dbus_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      HOLD,
      CANCEL
   } dbus_state_t;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   // Store size comes from how many byte enables are set, not from their position.
   function automatic logic [1:0] wen_to_size(input logic [3:0] wen);
      logic [2:0] n;
      n = {2'b0, wen[0]} + {2'b0, wen[1]} + {2'b0, wen[2]} + {2'b0, wen[3]};
      case (n)
         3'd1:    return SZ_BYTE;
         3'd2:    return SZ_HALF;
         default: return SZ_WORD;
      endcase
   endfunction

   function automatic logic [31:0] lane_replicate(input logic [31:0] d, input logic [1:0] size);
      case (size)
         SZ_BYTE: return {4{d[7:0]}};
         SZ_HALF: return {2{d[15:0]}};
         default: return d;
      endcase
   endfunction

endpackage

// File: rtl/mem_dbus_ctrl_load_align.sv
// load_align: combinational lane select and sign/zero extension of raw bus read data.
// Zero latency; shared with the uncached load path.
module load_align
   import mem_dbus_ctrl_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  size,
   input  logic        sign,
   output logic [31:0] data
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      case (addr_lo)
         2'd0:    byte_v = rdata[7:0];
         2'd1:    byte_v = rdata[15:8];
         2'd2:    byte_v = rdata[23:16];
         default: byte_v = rdata[31:24];
      endcase
      half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];
      case (size)
         SZ_BYTE: data = {{24{sign & byte_v[7]}}, byte_v};
         SZ_HALF: data = {{16{sign & half_v[15]}}, half_v};
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_dbus_ctrl.sv
// mem_dbus_ctrl: MEM-stage data-bus controller, one request/response per access, min 2-cycle latency; mem_stall holds the pipe.
// Define DBUS_TIMEOUT_EN to add a WAIT/CANCEL watchdog that raises mem_bus_err after TIMEOUT_CYCLES.
module mem_dbus_ctrl
   import mem_dbus_ctrl_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              mem_valid,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       mem_wdata,
   input  logic [3:0]        mem_wen,
   input  logic [1:0]        mem_ld_size,
   input  logic              mem_ld_sign,
   input  logic              mem_except,
   input  logic              mem_flush,
   input  logic              mem_wr,
   output logic              data_req,
   output logic              data_wr,
   output logic [1:0]        data_size,
   output logic [ADDR_W-1:0] data_addr,
   output logic [3:0]        data_wstrb,
   output logic [31:0]       data_wdata,
   input  logic              data_addr_ok,
   input  logic              data_data_ok,
   input  logic [31:0]       data_rdata,
   output logic [31:0]       mem_rdata,
   output logic              mem_stall,
   output logic              mem_bus_err
);

   dbus_state_t       state_q, state_d;
   logic              wr_q, wr_d;
   logic [1:0]        size_q, size_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [3:0]        wstrb_q, wstrb_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              sign_q, sign_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [31:0]       ld_data;
   logic              start, req, stall, timeout;

   assign start = (state_q == IDLE) & mem_valid & ~mem_except & ~mem_flush;

`ifdef DBUS_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             waiting;

   // Counter is zero in every other state, so it restarts on each entry to WAIT.
   assign waiting     = (state_q == WAIT) | (state_q == CANCEL);
   assign cnt_d       = waiting ? cnt_q + CNT_W'(1) : '0;
   assign timeout     = waiting & (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
   assign mem_bus_err = timeout;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end
`else
   assign timeout     = 1'b0;
   assign mem_bus_err = 1'b0;
`endif

   load_align u_load_align (
      .rdata   (data_rdata),
      .addr_lo (addr_q[1:0]),
      .size    (size_q),
      .sign    (sign_q),
      .data    (ld_data)
   );

   always_comb begin
      state_d = state_q;
      wr_d    = wr_q;
      size_d  = size_q;
      addr_d  = addr_q;
      wstrb_d = wstrb_q;
      wdata_d = wdata_q;
      sign_d  = sign_q;
      rdata_d = rdata_q;
      req     = 1'b0;
      stall   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               req     = 1'b1;
               stall   = 1'b1;
               wr_d    = |mem_wen;
               size_d  = (|mem_wen) ? wen_to_size(mem_wen) : mem_ld_size;
               addr_d  = mem_addr;
               wstrb_d = mem_wen;
               wdata_d = (|mem_wen) ? lane_replicate(mem_wdata, wen_to_size(mem_wen)) : 32'h0;
               sign_d  = mem_ld_sign;
               state_d = data_addr_ok ? WAIT : REQ;
            end
         end
         REQ: begin
            req   = 1'b1;
            stall = 1'b1;
            if (mem_flush)         state_d = data_addr_ok ? CANCEL : IDLE;
            else if (data_addr_ok) state_d = WAIT;
         end
         WAIT: begin
            stall = 1'b1;
            if (data_data_ok) begin
               stall = 1'b0;
               if (mem_flush) begin
                  state_d = IDLE;
               end else begin
                  rdata_d = ld_data;
                  state_d = mem_wr ? IDLE : HOLD;
               end
            end else if (timeout) begin
               stall   = 1'b0;
               rdata_d = 32'h0;
               state_d = IDLE;
            end else if (mem_flush) begin
               state_d = CANCEL;
            end
         end
         HOLD: begin
            if (mem_wr | mem_flush) state_d = IDLE;
         end
         CANCEL: begin
            if (data_data_ok) begin
               state_d = IDLE;
            end else if (timeout) begin
               rdata_d = 32'h0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         wr_q    <= 1'b0;
         size_q  <= 2'd0;
         addr_q  <= '0;
         wstrb_q <= 4'd0;
         wdata_q <= 32'h0;
         sign_q  <= 1'b0;
         rdata_q <= 32'h0;
      end else begin
         state_q <= state_d;
         wr_q    <= wr_d;
         size_q  <= size_d;
         addr_q  <= addr_d;
         wstrb_q <= wstrb_d;
         wdata_q <= wdata_d;
         sign_q  <= sign_d;
         rdata_q <= rdata_d;
      end
   end

   // Bus fields show the captured copy except in the launch cycle, where the new access goes out directly.
   assign data_req   = req;
   assign data_wr    = wr_d;
   assign data_size  = size_d;
   assign data_addr  = addr_d;
   assign data_wstrb = wstrb_d;
   assign data_wdata = wdata_d;
   assign mem_rdata  = rdata_d;
   assign mem_stall  = stall;

endmodule

// File: tb/tb_mem_dbus_ctrl.sv
// Directed, table-driven check of mem_dbus_ctrl with hand-computed expectations.
module tb_mem_dbus_ctrl;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        mem_valid, mem_ld_sign, mem_except, mem_flush, mem_wr;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wen;
   logic [1:0]  mem_ld_size;
   logic        data_req, data_wr, data_addr_ok, data_data_ok;
   logic [1:0]  data_size;
   logic [31:0] data_addr, data_wdata, data_rdata, mem_rdata;
   logic [3:0]  data_wstrb;
   logic        mem_stall, mem_bus_err;

   always #5 clk = ~clk;

   mem_dbus_ctrl #(.ADDR_W(32), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .resetn(resetn),
      .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen),
      .mem_ld_size(mem_ld_size), .mem_ld_sign(mem_ld_sign), .mem_except(mem_except),
      .mem_flush(mem_flush), .mem_wr(mem_wr),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
      .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
      .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .mem_rdata(mem_rdata), .mem_stall(mem_stall), .mem_bus_err(mem_bus_err)
   );

   typedef struct {
      string       name;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wen;
      logic [1:0]  ldsz;
      logic        sgn;
      logic [31:0] rdata;
      logic [1:0]  e_size;
      logic [31:0] e_wdata;
      logic [31:0] e_rdata;
   } vec_t;

   vec_t vt[8];
   int   total = 0;
   int   bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic clr();
      mem_valid = 0; mem_addr = 0; mem_wdata = 0; mem_wen = 0; mem_ld_size = 0;
      mem_ld_sign = 0; mem_except = 0; mem_flush = 0; mem_wr = 0;
      data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
   endtask

   task automatic set_ld(input logic [31:0] a, input logic [1:0] sz, input logic sg);
      mem_valid = 1; mem_addr = a; mem_wen = 0; mem_ld_size = sz; mem_ld_sign = sg;
   endtask

   initial begin
      vt[0] = '{"lb_s3",  32'h80000003, 32'h0,        4'b0000, 2'd0, 1'b1, 32'h80123456, 2'd0, 32'h0,        32'hFFFFFF80};
      vt[1] = '{"lhu_2",  32'h80000002, 32'h0,        4'b0000, 2'd1, 1'b0, 32'hBEEF1234, 2'd1, 32'h0,        32'h0000BEEF};
      vt[2] = '{"lh_s0",  32'h80000010, 32'h0,        4'b0000, 2'd1, 1'b1, 32'h12348001, 2'd1, 32'h0,        32'hFFFF8001};
      vt[3] = '{"lbu_1",  32'h80000021, 32'h0,        4'b0000, 2'd0, 1'b0, 32'h00C3A500, 2'd0, 32'h0,        32'h000000A5};
      vt[4] = '{"lw_4",   32'h80000004, 32'h0,        4'b0000, 2'd2, 1'b1, 32'hDEADBEEF, 2'd2, 32'h0,        32'hDEADBEEF};
      vt[5] = '{"sb_1",   32'h80000031, 32'h000000CD, 4'b0010, 2'd0, 1'b0, 32'h0,        2'd0, 32'hCDCDCDCD, 32'h0};
      vt[6] = '{"sh_2",   32'h80000042, 32'h00005678, 4'b1100, 2'd0, 1'b0, 32'h0,        2'd1, 32'h56785678, 32'h0};
      vt[7] = '{"sw_0",   32'h80000050, 32'hCAFEF00D, 4'b1111, 2'd0, 1'b0, 32'h0,        2'd2, 32'hCAFEF00D, 32'h0};

      clr();
      repeat (2) @(posedge clk);
      smp();
      chk("rst_req",   {31'b0, data_req},    32'h0);
      chk("rst_wr",    {31'b0, data_wr},     32'h0);
      chk("rst_size",  {30'b0, data_size},   32'h0);
      chk("rst_addr",  data_addr,            32'h0);
      chk("rst_wstrb", {28'b0, data_wstrb},  32'h0);
      chk("rst_wdata", data_wdata,           32'h0);
      chk("rst_rdata", mem_rdata,            32'h0);
      chk("rst_stall", {31'b0, mem_stall},   32'h0);
      chk("rst_err",   {31'b0, mem_bus_err}, 32'h0);
      cyc();
      resetn = 1;
      cyc();

      // Back-to-back accesses: addr_ok at launch, data_ok next cycle with mem_wr.
      for (int i = 0; i < 8; i++) begin
         mem_valid = 1; mem_addr = vt[i].addr; mem_wdata = vt[i].wdata; mem_wen = vt[i].wen;
         mem_ld_size = vt[i].ldsz; mem_ld_sign = vt[i].sgn; mem_wr = 0;
         data_addr_ok = 1; data_data_ok = 0;
         smp();
         chk($sformatf("%s_req", vt[i].name),   {31'b0, data_req},   32'h1);
         chk($sformatf("%s_stall", vt[i].name), {31'b0, mem_stall},  32'h1);
         chk($sformatf("%s_wr", vt[i].name),    {31'b0, data_wr},    {31'b0, vt[i].wen != 4'b0});
         chk($sformatf("%s_size", vt[i].name),  {30'b0, data_size},  {30'b0, vt[i].e_size});
         chk($sformatf("%s_wstrb", vt[i].name), {28'b0, data_wstrb}, {28'b0, vt[i].wen});
         chk($sformatf("%s_addr", vt[i].name),  data_addr,           vt[i].addr);
         if (vt[i].wen != 4'b0) chk($sformatf("%s_wdata", vt[i].name), data_wdata, vt[i].e_wdata);
         cyc();
         data_addr_ok = 0; data_data_ok = 1; data_rdata = vt[i].rdata; mem_wr = 1;
         smp();
         chk($sformatf("%s_done_stall", vt[i].name), {31'b0, mem_stall}, 32'h0);
         chk($sformatf("%s_done_req", vt[i].name),   {31'b0, data_req},  32'h0);
         if (vt[i].wen == 4'b0) chk($sformatf("%s_rdata", vt[i].name), mem_rdata, vt[i].e_rdata);
         cyc();
         data_data_ok = 0; mem_wr = 0;
      end
      clr();
      cyc();

      // Byte store, addr_ok after 3 extra cycles; inputs change under the held request.
      mem_valid = 1; mem_addr = 32'h10000006; mem_wdata = 32'h000000AB; mem_wen = 4'b0100;
      for (int k = 0; k < 4; k++) begin
         if (k == 1) begin mem_wdata = 32'h00000077; mem_addr = 32'h10000040; end
         data_addr_ok = (k == 3);
         smp();
         chk($sformatf("sb_hold%0d_req", k),   {31'b0, data_req},   32'h1);
         chk($sformatf("sb_hold%0d_wdata", k), data_wdata,          32'hABABABAB);
         chk($sformatf("sb_hold%0d_wstrb", k), {28'b0, data_wstrb}, 32'h4);
         chk($sformatf("sb_hold%0d_size", k),  {30'b0, data_size},  32'h0);
         chk($sformatf("sb_hold%0d_addr", k),  data_addr,           32'h10000006);
         chk($sformatf("sb_hold%0d_wr", k),    {31'b0, data_wr},    32'h1);
         cyc();
      end
      data_addr_ok = 0;
      smp();
      chk("sb_wait_req",   {31'b0, data_req},  32'h0);
      chk("sb_wait_stall", {31'b0, mem_stall}, 32'h1);
      cyc();
      data_data_ok = 1; mem_wr = 1;
      smp();
      chk("sb_done_stall", {31'b0, mem_stall}, 32'h0);
      cyc();
      clr();

      // Signed byte load: addr_ok one cycle late, then HOLD until mem_wr.
      set_ld(32'h80000003, 2'd0, 1'b1);
      smp();
      chk("a_c0_req",   {31'b0, data_req},  32'h1);
      chk("a_c0_stall", {31'b0, mem_stall}, 32'h1);
      cyc();
      data_addr_ok = 1;
      smp();
      chk("a_c1_req",   {31'b0, data_req},  32'h1);
      chk("a_c1_stall", {31'b0, mem_stall}, 32'h1);
      cyc();
      data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h80123456;
      smp();
      chk("a_c2_stall", {31'b0, mem_stall}, 32'h0);
      chk("a_c2_rdata", mem_rdata,          32'hFFFFFF80);
      cyc();
      data_data_ok = 0; data_rdata = 32'hFFFFFFFF; mem_wr = 1;
      smp();
      chk("a_hold_stall", {31'b0, mem_stall}, 32'h0);
      chk("a_hold_req",   {31'b0, data_req},  32'h0);
      chk("a_hold_rdata", mem_rdata,          32'hFFFFFF80);
      cyc();
      mem_wr = 0; mem_valid = 0;
      smp();
      chk("a_idle_req", {31'b0, data_req}, 32'h0);
      cyc();

      // Excepting instruction never reaches the bus.
      set_ld(32'h80000100, 2'd2, 1'b0);
      mem_except = 1;
      for (int k = 0; k < 3; k++) begin
         smp();
         chk($sformatf("exc%0d_req", k),   {31'b0, data_req},  32'h0);
         chk($sformatf("exc%0d_stall", k), {31'b0, mem_stall}, 32'h0);
         cyc();
      end
      clr();

      // Flush in WAIT -> CANCEL; data discarded, no request until the late data_ok.
      set_ld(32'h00000100, 2'd2, 1'b0);
      data_addr_ok = 1;
      smp();
      chk("d0_req", {31'b0, data_req}, 32'h1);
      cyc();
      data_addr_ok = 0; mem_valid = 0; mem_flush = 1;
      smp();
      chk("d1_stall", {31'b0, mem_stall}, 32'h1);
      cyc();
      mem_flush = 0;
      set_ld(32'h00000200, 2'd2, 1'b0);
      smp();
      chk("d2_req",   {31'b0, data_req},  32'h0);
      chk("d2_stall", {31'b0, mem_stall}, 32'h0);
      cyc();
      data_data_ok = 1; data_rdata = 32'h11111111;
      smp();
      chk("d3_req",   {31'b0, data_req}, 32'h0);
      chk("d3_rdata", mem_rdata,         32'hFFFFFF80);
      cyc();
      data_data_ok = 0; data_addr_ok = 1;
      smp();
      chk("d4_req",   {31'b0, data_req}, 32'h1);
      chk("d4_addr",  data_addr,         32'h00000200);
      chk("d4_rdata", mem_rdata,         32'hFFFFFF80);
      cyc();
      data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h22222222; mem_wr = 1;
      smp();
      chk("d5_rdata", mem_rdata,          32'h22222222);
      chk("d5_stall", {31'b0, mem_stall}, 32'h0);
      cyc();
      clr();

      // Flush together with data_ok in WAIT: straight to IDLE, data discarded.
      set_ld(32'h00000300, 2'd2, 1'b0);
      data_addr_ok = 1;
      smp();
      chk("e0_req", {31'b0, data_req}, 32'h1);
      cyc();
      data_addr_ok = 0; mem_valid = 0; mem_flush = 1; data_data_ok = 1; data_rdata = 32'h33333333;
      smp();
      chk("e1_stall", {31'b0, mem_stall}, 32'h0);
      chk("e1_rdata", mem_rdata,          32'h22222222);
      cyc();
      mem_flush = 0; data_data_ok = 0;
      set_ld(32'h00000304, 2'd2, 1'b0);
      data_addr_ok = 1;
      smp();
      chk("e2_req", {31'b0, data_req}, 32'h1);
      cyc();
      data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h44444444; mem_wr = 1;
      smp();
      chk("e3_rdata", mem_rdata, 32'h44444444);
      cyc();
      clr();

      // Flush in REQ before addr_ok: request dropped next cycle, stray data_ok ignored.
      set_ld(32'h00000400, 2'd2, 1'b0);
      smp();
      chk("f0_req", {31'b0, data_req}, 32'h1);
      cyc();
      mem_flush = 1; mem_valid = 0;
      smp();
      chk("f1_req", {31'b0, data_req}, 32'h1);
      cyc();
      mem_flush = 0; data_data_ok = 1; data_rdata = 32'h55555555;
      smp();
      chk("f2_req",   {31'b0, data_req},  32'h0);
      chk("f2_stall", {31'b0, mem_stall}, 32'h0);
      chk("f2_rdata", mem_rdata,          32'h44444444);
      cyc();
      clr();
      smp();
      chk("f3_rdata", mem_rdata, 32'h44444444);
      cyc();

      // data_ok withheld.
      set_ld(32'h00000500, 2'd2, 1'b0);
      data_addr_ok = 1;
      smp();
      chk("g0_req", {31'b0, data_req}, 32'h1);
      cyc();
      data_addr_ok = 0;
`ifdef DBUS_TIMEOUT_EN
      for (int w = 1; w <= 8; w++) begin
         smp();
         chk($sformatf("to_w%0d_err", w),   {31'b0, mem_bus_err}, (w == 8) ? 32'h1 : 32'h0);
         chk($sformatf("to_w%0d_stall", w), {31'b0, mem_stall},   (w == 8) ? 32'h0 : 32'h1);
         if (w == 8) chk("to_rdata", mem_rdata, 32'h0);
         cyc();
      end
      set_ld(32'h00000600, 2'd2, 1'b0);
      data_addr_ok = 1;
      smp();
      chk("to_idle_req", {31'b0, data_req},    32'h1);
      chk("to_idle_err", {31'b0, mem_bus_err}, 32'h0);
      cyc();
      data_addr_ok = 0;
`else
      for (int w = 1; w <= 20; w++) begin
         smp();
         chk($sformatf("nto_w%0d_err", w),   {31'b0, mem_bus_err}, 32'h0);
         chk($sformatf("nto_w%0d_stall", w), {31'b0, mem_stall},   32'h1);
         cyc();
      end
`endif
      data_data_ok = 1; data_rdata = 32'h66666666; mem_wr = 1;
      smp();
      chk("g_done_rdata", mem_rdata,          32'h66666666);
      chk("g_done_stall", {31'b0, mem_stall}, 32'h0);
      cyc();
      clr();

      // Asynchronous reset while a request is pending; late data_ok ignored.
      set_ld(32'h00000700, 2'd2, 1'b0);
      smp();
      chk("h0_req", {31'b0, data_req}, 32'h1);
      cyc();
      #2;
      resetn = 0; mem_valid = 0;
      #1;
      chk("h_rst_req",   {31'b0, data_req},  32'h0);
      chk("h_rst_stall", {31'b0, mem_stall}, 32'h0);
      chk("h_rst_addr",  data_addr,          32'h0);
      chk("h_rst_rdata", mem_rdata,          32'h0);
      cyc();
      resetn = 1; data_data_ok = 1; data_rdata = 32'h77777777;
      smp();
      chk("h_late_rdata", mem_rdata,          32'h0);
      chk("h_late_req",   {31'b0, data_req},  32'h0);
      chk("h_late_stall", {31'b0, mem_stall}, 32'h0);
      cyc();
      clr();
      smp();
      chk("h_after_rdata", mem_rdata, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
